// File: rtl/decode_flow_ctl.sv
// Decode-stage sequencing: nuke flush hold, EBREAK drain/halt, single-cycle fetch redirect.
// Optional perf counters are enabled by defining DECODE_FLOW_PERF_EN.
module decode_flow_ctl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 64
`ifdef DECODE_FLOW_PERF_EN
  , parameter int PERF_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nuke_valid_rb1,
  input  logic [PC_W-1:0]   nuke_pc_rb1,
  input  logic              ebreak_push_de0,
  input  logic              uopq_empty,
  input  logic              uopq_full,
  input  logic              resume,
  output logic              decode_en_de0,
  output logic              uopq_flush,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              halted,
`ifdef DECODE_FLOW_PERF_EN
  output logic [PERF_W-1:0] perf_flush_cycles,
  output logic [PERF_W-1:0] perf_halt_cycles,
`endif
  output logic [1:0]        state
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [PC_W-1:0]   cap_pc_r, cap_pc_nxt_s;
  logic              redir_nxt_s;
  logic [PC_W-1:0]   redir_pc_nxt_s;

  // Next-state, flush counter and PC capture; a nuke overrides everything else.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    cap_pc_nxt_s   = cap_pc_r;
    redir_nxt_s    = 1'b0;
    redir_pc_nxt_s = redirect_pc;
    if (nuke_valid_rb1) begin
      state_nxt_s  = ST_FLUSH;
      cap_pc_nxt_s = nuke_pc_rb1;
      cnt_nxt_s    = CNT_W'(FLUSH_CYCLES - 1);
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ebreak_push_de0) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt_s    = ST_RUN;
            redir_nxt_s    = 1'b1;
            redir_pc_nxt_s = cap_pc_r;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (uopq_empty) begin
            state_nxt_s = ST_HALTED;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_HALTED: begin
          // Leaving a debug halt restarts in place, so no redirect is raised here.
          if (resume) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HALTED;
          end
        end
        default: state_nxt_s = ST_RUN;
      endcase
    end
  end

  // State, counter, captured PC and registered redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_RUN;
      cnt_r          <= {CNT_W{1'b0}};
      cap_pc_r       <= {PC_W{1'b0}};
      redirect_valid <= 1'b0;
      redirect_pc    <= {PC_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      cap_pc_r       <= cap_pc_nxt_s;
      redirect_valid <= redir_nxt_s;
      redirect_pc    <= redir_pc_nxt_s;
    end
  end

  assign decode_en_de0 = (state_r == ST_RUN) & ~nuke_valid_rb1 & ~uopq_full & ~reset;
  assign uopq_flush    = nuke_valid_rb1 | (state_r == ST_FLUSH) | reset;
  assign halted        = (state_r == ST_HALTED);
  assign state         = state_r;

`ifdef DECODE_FLOW_PERF_EN
  // Saturating occupancy counters for flush and drain/halt residency.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_flush_cycles <= {PERF_W{1'b0}};
      perf_halt_cycles  <= {PERF_W{1'b0}};
    end else begin
      if ((state_r == ST_FLUSH) && (perf_flush_cycles != {PERF_W{1'b1}})) begin
        perf_flush_cycles <= perf_flush_cycles + PERF_W'(1);
      end
      if (((state_r == ST_DRAIN) || (state_r == ST_HALTED)) &&
          (perf_halt_cycles != {PERF_W{1'b1}})) begin
        perf_halt_cycles <= perf_halt_cycles + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_flow_ctl.sv
// Scoreboard bench for decode_flow_ctl: per-cycle expectations are queued when inputs are
// driven and compared against DUT outputs on the following falling edge.
module tb_decode_flow_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nuke_valid_rb1 = 1'b0;
  logic [63:0] nuke_pc_rb1 = 64'd0;
  logic        ebreak_push_de0 = 1'b0;
  logic        uopq_empty = 1'b1;
  logic        uopq_full = 1'b0;
  logic        resume = 1'b0;
  logic        decode_en_de0;
  logic        uopq_flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;
  logic [1:0]  state;
`ifdef DECODE_FLOW_PERF_EN
  logic [2:0]  perf_flush_cycles;
  logic [2:0]  perf_halt_cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  st;
    logic        en;
    logic        fl;
    logic        rv;
    logic [63:0] rpc;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] P1 = 64'h0000_0000_8000_0100;
  localparam logic [63:0] P2 = 64'h0000_0000_0000_0200;
  localparam logic [63:0] P3 = 64'h0000_0000_0000_3000;
  localparam logic [63:0] P4 = 64'h0000_0000_0000_4000;
  localparam logic [63:0] P5 = 64'h0000_0000_0000_5000;
  localparam logic [63:0] PX = 64'h0000_0000_0000_1000;

  decode_flow_ctl #(
    .FLUSH_CYCLES(2),
    .PC_W(64)
`ifdef DECODE_FLOW_PERF_EN
    , .PERF_W(3)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .nuke_valid_rb1(nuke_valid_rb1),
    .nuke_pc_rb1(nuke_pc_rb1),
    .ebreak_push_de0(ebreak_push_de0),
    .uopq_empty(uopq_empty),
    .uopq_full(uopq_full),
    .resume(resume),
    .decode_en_de0(decode_en_de0),
    .uopq_flush(uopq_flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted),
`ifdef DECODE_FLOW_PERF_EN
    .perf_flush_cycles(perf_flush_cycles),
    .perf_halt_cycles(perf_halt_cycles),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge and queue what the cycle must show.
  task automatic cyc(input logic r, input logic n, input logic [63:0] pc, input logic eb,
                     input logic emp, input logic full, input logic res,
                     input logic [1:0] st, input logic en, input logic fl, input logic rv,
                     input logic [63:0] rpc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; nuke_valid_rb1 = n; nuke_pc_rb1 = pc; ebreak_push_de0 = eb;
    uopq_empty = emp; uopq_full = full; resume = res;
    e.st = st; e.en = en; e.fl = fl; e.rv = rv; e.rpc = rpc;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("state", 64'(state), 64'(e.st));
      check_eq("decode_en", 64'(decode_en_de0), 64'(e.en));
      check_eq("uopq_flush", 64'(uopq_flush), 64'(e.fl));
      check_eq("redirect_valid", 64'(redirect_valid), 64'(e.rv));
      check_eq("redirect_pc", redirect_pc, e.rpc);
      check_eq("halted", 64'(halted), 64'(e.st == 2'd3));
    end
  end

  initial begin
    // reset held, then release with an idle, non-full queue
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 64'd0);
    // nuke from RUN
    cyc(1'b0, 1'b1, P1,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, P1);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, P1);
    // second nuke in the last FLUSH cycle extends the flush; latest PC wins
    cyc(1'b0, 1'b1, PX,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, P1);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P1);
    cyc(1'b0, 1'b1, P2,    1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P1);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P1);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P1);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, P2);
    // EBREAK: drain 4 cycles on a busy queue, halt, resume without redirect
    cyc(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, P2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, P2);
    // EBREAK with an already-empty queue, then nuke+resume together while HALTED
    cyc(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, P2);
    cyc(1'b0, 1'b1, P3,    1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P2);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, P3);
    // full queue blocks decode without leaving RUN
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, P3);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, P3);
    // nuke while draining
    cyc(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, P3);
    cyc(1'b0, 1'b1, P4,    1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, P3);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P3);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P3);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, P4);
    // reset in the middle of a flush clears everything
    cyc(1'b0, 1'b1, P5,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, P4);
`ifdef DECODE_FLOW_PERF_EN
    @(negedge clk);
    check_eq("perf_flush_sat", 64'(perf_flush_cycles), 64'd7);
    check_eq("perf_halt_sat", 64'(perf_halt_cycles), 64'd7);
`endif
    cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, P4);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 64'd0);
`ifdef DECODE_FLOW_PERF_EN
    @(negedge clk);
    check_eq("perf_flush_clr", 64'(perf_flush_cycles), 64'd0);
    check_eq("perf_halt_clr", 64'(perf_halt_cycles), 64'd0);
`endif
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
